// File: rtl/nes_clk_pkg.sv
// ---------------------------------------------------------------------------
// nes_clk_pkg
// Shared definitions for the NES PLL clock sequencer:
//   STATE_W  - width of the debug state code
//   state_e  - FSM state codes (S_RESET=0 .. S_FAIL=4); codes 5-7 are unused
//   max3     - helper used to size the shared cycle counter
// ---------------------------------------------------------------------------
package nes_clk_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_RESET     = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_SETTLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_e;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/nes_bit_sync.sv
// ---------------------------------------------------------------------------
// nes_bit_sync
// Two-flop synchronizer for a single asynchronous status bit.
// Ports:
//   clk  - destination clock
//   rst  - synchronous, active-high; clears both flops
//   d_i  - asynchronous input bit
//   q_o  - synchronized output (two clk edges of latency)
// ---------------------------------------------------------------------------
module nes_bit_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of the other; blocking here would collapse the chain
  // into a single flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/nes_clk_sequencer.sv
// ---------------------------------------------------------------------------
// nes_clk_sequencer
// Power-up / recovery sequencer for the NES PLL. Pulses the PLL reset, waits
// for a qualified lock (timeout + bounded retries), holds downstream logic in
// reset for a settle window, then supervises lock during operation.
// Ports:
//   clk             - PLL reference clock (only clock)
//   rst             - synchronous, active-high reset
//   pll_locked      - PLL LOCKED, asynchronous to clk
//   force_restart   - single-cycle pulse: restart and clear retry_count
//   pll_rst         - PLL reset
//   sys_rst         - downstream reset, active high
//   clk_ready       - high only in RUN
//   lock_fail       - high only in FAIL
//   retry_count     - failed attempts since last success / force_restart
//   lock_lost_count - loss-of-lock events in RUN, saturating at 255
//   state           - current FSM state code (debug)
// ---------------------------------------------------------------------------
module nes_clk_sequencer
  import nes_clk_pkg::*;
#(
  parameter int unsigned RESET_CYCLES  = 16,
  parameter int unsigned LOCK_TIMEOUT  = 50000,
  parameter int unsigned SETTLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES   = 4,
  parameter int unsigned LOSS_FILTER   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pll_locked,
  input  logic               force_restart,
  output logic               pll_rst,
  output logic               sys_rst,
  output logic               clk_ready,
  output logic               lock_fail,
  output logic [3:0]         retry_count,
  output logic [7:0]         lock_lost_count,
  output logic [STATE_W-1:0] state
);

  localparam int unsigned CNT_MAX = max3(RESET_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES);
  localparam int          CNT_W   = $clog2(CNT_MAX) + 1;
  localparam int          LOSS_W  = $clog2(LOSS_FILTER + 1);

  logic              sync_locked;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LOSS_W-1:0] loss_q, loss_d;
  logic [3:0]        retry_q, retry_d;
  logic [7:0]        lost_q, lost_d;
  logic              attempt_fail;
  logic              pll_rst_q, sys_rst_q, clk_ready_q, lock_fail_q;

  nes_bit_sync u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d_i (pll_locked),
    .q_o (sync_locked)
  );

  // Next-state logic.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case leaves it unassigned and no latch is inferred.
    state_d      = state_q;
    cnt_d        = cnt_q + CNT_W'(1);
    retry_d      = retry_q;
    lost_d       = lost_q;
    loss_d       = '0;
    attempt_fail = 1'b0;

    unique case (state_q)
      S_RESET: begin
        if (cnt_q == CNT_W'(RESET_CYCLES - 1)) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      S_WAIT_LOCK: begin
        if (sync_locked) begin
          state_d = S_SETTLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
          attempt_fail = 1'b1;
        end
      end
      S_SETTLE: begin
        // Any dropout during settle discards the attempt like a timeout.
        if (!sync_locked) begin
          attempt_fail = 1'b1;
        end else if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          state_d = S_RUN;
          cnt_d   = '0;
          retry_d = '0;
        end
      end
      S_RUN: begin
        cnt_d = '0;
        // loss_d defaults to 0, so any locked sample restarts the filter.
        if (!sync_locked) begin
          if (loss_q == LOSS_W'(LOSS_FILTER - 1)) begin
            lost_d  = (lost_q == 8'hFF) ? lost_q : lost_q + 8'd1;
            state_d = S_RESET;
          end else begin
            loss_d = loss_q + LOSS_W'(1);
          end
        end
      end
      S_FAIL: begin
        cnt_d = '0;
      end
      default: begin
        state_d = S_RESET;
        cnt_d   = '0;
      end
    endcase

    if (attempt_fail) begin
      retry_d = retry_q + 4'd1;
      cnt_d   = '0;
      state_d = (retry_q + 4'd1 == 4'(MAX_RETRIES)) ? S_FAIL : S_RESET;
    end

    // A restart overrides any same-cycle timeout or loss event; the loss
    // counter is left untouched in that case.
    if (force_restart) begin
      state_d = S_RESET;
      cnt_d   = '0;
      retry_d = '0;
      lost_d  = lost_q;
      loss_d  = '0;
    end
  end

  // State, counters and registered outputs. Outputs decode state_d so they
  // switch on the same edge as the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RESET;
      cnt_q       <= '0;
      loss_q      <= '0;
      retry_q     <= '0;
      lost_q      <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_q   <= 1'b1;
      clk_ready_q <= 1'b0;
      lock_fail_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      loss_q      <= loss_d;
      retry_q     <= retry_d;
      lost_q      <= lost_d;
      pll_rst_q   <= (state_d == S_RESET) || (state_d == S_FAIL);
      sys_rst_q   <= (state_d != S_RUN);
      clk_ready_q <= (state_d == S_RUN);
      lock_fail_q <= (state_d == S_FAIL);
    end
  end

  assign pll_rst         = pll_rst_q;
  assign sys_rst         = sys_rst_q;
  assign clk_ready       = clk_ready_q;
  assign lock_fail       = lock_fail_q;
  assign retry_count     = retry_q;
  assign lock_lost_count = lost_q;
  assign state           = state_q;

endmodule
